// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the DataMemory arbiter: state encoding, port indices,
// default widths and the fixed-priority-with-aging winner selection.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_WAIT = 4;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } arb_state_t;

    // The CPU port wins unless the aux port has lost too many contested rounds.
    function automatic logic pick_winner(input logic req_cpu, input logic req_aux,
                                         input logic aux_due);
        return (req_aux && (!req_cpu || aux_due)) ? PORT_AUX : PORT_CPU;
    endfunction

endpackage

// File: rtl/arb_age_counter.sv
// Saturating wait counter: counts lost arbitration rounds of a low-priority
// requester and flags when it must be served next.
module arb_age_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_at_limit = (r_cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 16-bit DataMemory: one access per
// grant (IDLE -> ACCESS -> ACK), registered read data and a one-cycle ack.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
);

    arb_state_t        r_state;
    logic              r_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_wen;
    logic              r_ren;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_busy;

    logic w_idle;
    logic w_at_limit;
    logic w_win;
    logic w_inc;
    logic w_clr;

    assign w_idle = (r_state == ST_IDLE);
    assign w_win  = pick_winner(req0, req1, w_at_limit);
    // Aging only advances on contested CPU wins; any aux grant or idle aux port resets it.
    assign w_inc  = w_idle & req0 & req1 & (w_win == PORT_CPU);
    assign w_clr  = w_idle & (~req1 | (w_win == PORT_AUX));

    arb_age_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_inc),
        .i_clr      (w_clr),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= PORT_CPU;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_wen    <= 1'b0;
            r_ren    <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        r_grant <= w_win;
                        r_addr  <= (w_win == PORT_AUX) ? addr1  : addr0;
                        r_wdata <= (w_win == PORT_AUX) ? wdata1 : wdata0;
                        r_wen   <= (w_win == PORT_AUX) ? we1    : we0;
                        r_ren   <= (w_win == PORT_AUX) ? ~we1   : ~we0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_ren) begin
                        if (r_grant == PORT_AUX) r_rdata1 <= mem_out;
                        else                     r_rdata0 <= mem_out;
                    end
                    r_wen   <= 1'b0;
                    r_ren   <= 1'b0;
                    r_ack0  <= (r_grant == PORT_CPU);
                    r_ack1  <= (r_grant == PORT_AUX);
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_wen   <= 1'b0;
                    r_ren   <= 1'b0;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_access_addr = r_addr;
    assign mem_in          = r_wdata;
    assign mem_write_en    = r_wen;
    assign mem_read_en     = r_ren;
    assign ack0            = r_ack0;
    assign ack1            = r_ack1;
    assign rdata0          = r_rdata0;
    assign rdata1          = r_rdata1;
    assign busy            = r_busy;

endmodule
